// File: rtl/vend_withdraw_ctrl.sv
// Purpose : money-vault withdrawal controller. Holds the balance, takes deposits
//           every cycle and pays out approved withdrawals one coin per cycle.
// Latency : accepted request of N pays coins in cycles k+1..k+N, done in k+N+1,
//           ready again in k+N+2; a rejected request shows redlight for ERR_HOLD
//           cycles and is ready again in k+ERR_HOLD+1.
// Backpr. : wd_ready is high only in IDLE; the requester holds wd_valid until accepted.
//           Deposits are never back-pressured; an overflowing deposit saturates.
//
// Ports:
//   clock, reset_n                 - rising-edge clock, async active-low reset
//   deposit_valid, deposit_amount  - add deposit_amount to the balance this cycle
//   wd_valid, wd_ready, wd_amount  - withdraw request handshake (amount sampled on accept)
//   coin_out                       - one pulse per unit dispensed
//   busy, done                     - not-IDLE indicator, one-cycle completion pulse
//   redlight                       - rejected request (held) or deposit saturation (pulse)
//   balance, sevensegment          - registered balance and hex digit of balance[3:0]
//                                    ({g,f,e,d,c,b,a}, 1 = lit)
module vend_withdraw_ctrl #(
  parameter int WIDTH        = 8,
  parameter int INIT_BALANCE = 0,
  parameter int ERR_HOLD     = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             deposit_valid,
  input  logic [WIDTH-1:0] deposit_amount,
  input  logic             wd_valid,
  output logic             wd_ready,
  input  logic [WIDTH-1:0] wd_amount,
  output logic             coin_out,
  output logic             busy,
  output logic             done,
  output logic             redlight,
  output logic [WIDTH-1:0] balance,
  output logic [6:0]       sevensegment
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DISPENSE = 2'd1;
  localparam logic [1:0] ST_DONE     = 2'd2;
  localparam logic [1:0] ST_ERROR    = 2'd3;

  localparam logic [WIDTH-1:0] BAL_INIT = WIDTH'(INIT_BALANCE);
  localparam logic [WIDTH-1:0] ERR_LOAD = WIDTH'(ERR_HOLD);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH:0]   BAL_MAX  = {1'b0, {WIDTH{1'b1}}};

  // Hex digit decode, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    seg = 7'h00;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] remaining;
  logic [WIDTH-1:0] remaining_nxt;
  logic [WIDTH-1:0] err_cnt;
  logic [WIDTH-1:0] err_cnt_nxt;
  logic             sat_pulse;
  logic             sat_nxt;
  logic [WIDTH:0]   bal_sum;
  logic [WIDTH-1:0] bal_nxt;
  logic             handshake;
  logic             req_bad;

  // Outputs decoded straight from state so an async reset drops them at once.
  assign wd_ready  = (state == ST_IDLE);
  assign coin_out  = (state == ST_DISPENSE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign redlight  = (state == ST_ERROR) || sat_pulse;

  assign handshake = wd_valid && wd_ready;
  // Judged against the registered balance, i.e. before any same-cycle deposit.
  assign req_bad   = (wd_amount == '0) || (wd_amount > balance);

  // Balance update in WIDTH+1 bits. Subtracting the coin cannot underflow:
  // dispensing only starts when the amount fits, so balance >= remaining >= 1.
  always_comb begin
    bal_sum = {1'b0, balance}
            + ({1'b0, deposit_amount} & {(WIDTH+1){deposit_valid}})
            - {{WIDTH{1'b0}}, coin_out};
    bal_nxt = bal_sum[WIDTH-1:0];
    sat_nxt = 1'b0;
    if (bal_sum > BAL_MAX) begin
      bal_nxt = {WIDTH{1'b1}};
      sat_nxt = 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    err_cnt_nxt   = err_cnt;
    case (state)
      ST_IDLE: begin
        if (handshake) begin
          if (req_bad) begin
            state_nxt   = ST_ERROR;
            err_cnt_nxt = ERR_LOAD;
          end else begin
            state_nxt     = ST_DISPENSE;
            remaining_nxt = wd_amount;
          end
        end
      end
      ST_DISPENSE: begin
        remaining_nxt = remaining - ONE;
        if (remaining == ONE) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      ST_ERROR: begin
        err_cnt_nxt = err_cnt - ONE;
        if (err_cnt == ONE) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      remaining    <= '0;
      err_cnt      <= '0;
      sat_pulse    <= 1'b0;
      balance      <= BAL_INIT;
      sevensegment <= seg_decode(BAL_INIT[3:0]);
    end else begin
      state        <= state_nxt;
      remaining    <= remaining_nxt;
      err_cnt      <= err_cnt_nxt;
      sat_pulse    <= sat_nxt;
      balance      <= bal_nxt;
      // Decoded from the next balance so the digit never lags the register.
      sevensegment <= seg_decode(bal_nxt[3:0]);
    end
  end

endmodule

// File: tb/tb_vend_withdraw_ctrl.sv
// Purpose : self-checking bench for vend_withdraw_ctrl (directed plan + random traffic).
// Latency : expectations come from a cycle-indexed timeline model (accept cycle + amount).
// Backpr. : the bench holds wd_valid with a fixed amount until the model sees it accepted.
module tb_vend_withdraw_ctrl;

  localparam int EH   = 4;
  localparam int INIT = 9;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       deposit_valid;
  logic [7:0] deposit_amount;
  logic       wd_valid;
  logic       wd_ready;
  logic [7:0] wd_amount;
  logic       coin_out, busy, done, redlight;
  logic [7:0] balance;
  logic [6:0] sevensegment;

  // 4-bit instance used for the saturation case.
  logic       d4_dv;
  logic [3:0] d4_da;
  logic       d4_wv;
  logic [3:0] d4_wa;
  logic       d4_rdy, d4_coin, d4_busy, d4_done, d4_red;
  logic [3:0] d4_bal;
  logic [6:0] d4_seg;

  always #5 clock = ~clock;

  vend_withdraw_ctrl #(.WIDTH(8), .INIT_BALANCE(INIT), .ERR_HOLD(EH)) dut (
    .clock(clock), .reset_n(reset_n),
    .deposit_valid(deposit_valid), .deposit_amount(deposit_amount),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_amount(wd_amount),
    .coin_out(coin_out), .busy(busy), .done(done), .redlight(redlight),
    .balance(balance), .sevensegment(sevensegment)
  );

  vend_withdraw_ctrl #(.WIDTH(4), .INIT_BALANCE(14), .ERR_HOLD(EH)) dut4 (
    .clock(clock), .reset_n(reset_n),
    .deposit_valid(d4_dv), .deposit_amount(d4_da),
    .wd_valid(d4_wv), .wd_ready(d4_rdy), .wd_amount(d4_wa),
    .coin_out(d4_coin), .busy(d4_busy), .done(d4_done), .redlight(d4_red),
    .balance(d4_bal), .sevensegment(d4_seg)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex7(input int v);
    logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[v % 16];
  endfunction

  // Timeline model: the last accepted request and when it was accepted.
  int cyc = 0;
  int mbal = INIT;
  bit sat_prev = 0;
  bit have_acc = 0;
  int acc_c, acc_n;
  bit acc_ok;
  bit last_hs;
  int coin_seen, done_seen, red_seen;

  task automatic step(input bit dv, input logic [7:0] da, input bit wv, input logic [7:0] wa);
    bit e_coin, e_done, e_busy, e_err, e_rdy;
    int nb;
    deposit_valid = dv; deposit_amount = da; wd_valid = wv; wd_amount = wa;
    #1;
    e_coin = 0; e_done = 0; e_busy = 0; e_err = 0; e_rdy = 1;
    if (have_acc && acc_ok) begin
      e_coin = (cyc > acc_c) && (cyc <= acc_c + acc_n);
      e_done = (cyc == acc_c + acc_n + 1);
      e_busy = (cyc > acc_c) && (cyc <= acc_c + acc_n + 1);
      e_rdy  = (cyc > acc_c + acc_n + 1);
    end else if (have_acc) begin
      e_err  = (cyc > acc_c) && (cyc <= acc_c + EH);
      e_busy = e_err;
      e_rdy  = (cyc > acc_c + EH);
    end
    check_eq("wd_ready", wd_ready, e_rdy);
    check_eq("coin_out", coin_out, e_coin);
    check_eq("done", done, e_done);
    check_eq("busy", busy, e_busy);
    check_eq("redlight", redlight, e_err | sat_prev);
    check_eq("balance", balance, mbal);
    check_eq("sevensegment", sevensegment, hex7(mbal));
    if (coin_out) coin_seen++;
    if (done) done_seen++;
    if (redlight) red_seen++;
    last_hs = wv && e_rdy;
    if (last_hs) begin
      have_acc = 1; acc_c = cyc; acc_n = wa;
      acc_ok = (wa != 0) && (int'(wa) <= mbal);
    end
    nb = mbal + (dv ? int'(da) : 0) - (e_coin ? 1 : 0);
    sat_prev = (nb > 255);
    mbal = sat_prev ? 255 : nb;
    @(posedge clock); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'd0, 0, 8'd0);
  endtask

  task automatic send_wd(input logic [7:0] amt);
    int n = 0;
    do begin
      step(0, 8'd0, 1, amt);
      n++;
    end while (!last_hs && n < 100);
    check_eq("accept_timeout", last_hs, 1);
  endtask

  task automatic zero_counts();
    coin_seen = 0; done_seen = 0; red_seen = 0;
  endtask

  // Async reset asserted mid-cycle; outputs must drop without waiting for an edge.
  task automatic mid_reset();
    deposit_valid = 0; wd_valid = 0;
    reset_n = 0;
    #1;
    check_eq("rst_coin", coin_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", wd_ready, 1);
    check_eq("rst_balance", balance, INIT);
    check_eq("rst_seg", sevensegment, 7'h6F);
    @(negedge clock);
    reset_n = 1;
    have_acc = 0; mbal = INIT; sat_prev = 0;
    @(posedge clock); #1;
    cyc++;
  endtask

  int k1, k2;
  bit pend;
  logic [7:0] pa;
  int lim;
  bit rdv;
  logic [7:0] rda;

  initial begin
    reset_n = 0;
    deposit_valid = 0; deposit_amount = 0; wd_valid = 0; wd_amount = 0;
    d4_dv = 0; d4_da = 0; d4_wv = 0; d4_wa = 0;
    #12;
    check_eq("reset_ready", wd_ready, 1);
    check_eq("reset_coin", coin_out, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_red", redlight, 0);
    check_eq("reset_balance", balance, 9);
    check_eq("reset_seg", sevensegment, 7'h6F);
    check_eq("reset_bal4", d4_bal, 14);
    check_eq("reset_seg4", d4_seg, 7'h79);
    @(negedge clock);
    reset_n = 1;
    @(posedge clock); #1;

    // 4-bit saturation: 14 + 5 clips to 15 with a single redlight cycle.
    d4_dv = 1; d4_da = 4'd5;
    idle(1);
    d4_dv = 0; d4_da = 0;
    check_eq("sat4_balance", d4_bal, 15);
    check_eq("sat4_red", d4_red, 1);
    check_eq("sat4_seg", d4_seg, 7'h71);
    check_eq("sat4_busy", d4_busy, 0);
    idle(1);
    check_eq("sat4_red_clear", d4_red, 0);
    check_eq("sat4_hold", d4_bal, 15);

    // 9 - 3 = 6.
    zero_counts();
    send_wd(8'd3);
    idle(5);
    check_eq("wd3_coins", coin_seen, 3);
    check_eq("wd3_done", done_seen, 1);
    check_eq("wd3_balance", balance, 6);
    check_eq("wd3_seg", sevensegment, 7'h7D);

    // Down to 5, then over-withdraw and zero-withdraw are both rejected.
    send_wd(8'd1);
    idle(3);
    zero_counts();
    send_wd(8'd6);
    idle(6);
    check_eq("over_red_cycles", red_seen, EH);
    check_eq("over_coins", coin_seen, 0);
    check_eq("over_balance", balance, 5);
    zero_counts();
    send_wd(8'd0);
    idle(6);
    check_eq("zero_red_cycles", red_seen, EH);
    check_eq("zero_coins", coin_seen, 0);
    check_eq("zero_balance", balance, 5);

    // Down to 4, then withdraw all of it while depositing 2 every dispense cycle.
    send_wd(8'd1);
    idle(3);
    zero_counts();
    send_wd(8'd4);
    for (int i = 0; i < 4; i++) step(1, 8'd2, 0, 8'd0);
    idle(2);
    check_eq("dep_wd_coins", coin_seen, 4);
    check_eq("dep_wd_balance", balance, 8);

    // wd_valid held high: amount 2 then 1; second accept lands 4 cycles later.
    zero_counts();
    send_wd(8'd2);
    k1 = acc_c;
    send_wd(8'd1);
    k2 = acc_c;
    idle(4);
    check_eq("b2b_gap", k2 - k1, 4);
    check_eq("b2b_coins", coin_seen, 3);
    check_eq("b2b_done", done_seen, 2);
    check_eq("b2b_balance", balance, 5);

    // Abort a withdraw of 10 from 20 partway through.
    step(1, 8'd15, 0, 8'd0);
    send_wd(8'd10);
    idle(4);
    check_eq("abort_pre_coin", coin_out, 1);
    mid_reset();
    idle(2);

    // Random traffic with occasional resets.
    pend = 0; pa = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!pend && $urandom_range(0, 3) == 0) begin
        pend = 1;
        lim = (mbal + 2 > 40) ? 40 : mbal + 2;
        pa = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, lim));
      end
      rdv = ($urandom_range(0, 4) == 0);
      rda = ($urandom_range(0, 49) == 0) ? 8'($urandom_range(150, 255))
                                          : 8'($urandom_range(0, 3));
      step(rdv, rda, pend, pa);
      if (last_hs) pend = 0;
      if (i % 300 == 299) mid_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
